// File: rtl/iram_mp.sv
// -----------------------------------------------------------------------------
// iram_mp - multi-port instruction memory shared by NUM_CORES fetch ports.
//
// One physical read per cycle. A round-robin arbiter picks it, and a
// program-load write port takes priority over all reads. Each core has its
// own registered rdata/rvalid/err outputs.
//
// Build option: define IRAM_MP_BOUNDS_EN to enable bounds checking.
//   - An out-of-range read returns ENDOP_WORD and raises err.
//   - An out-of-range write is dropped and raises wr_err.
// Without it, addresses wrap modulo DEPTH, and err/wr_err stay 0.
//
// Ports:
//   clk      in  1                    rising-edge clock
//   rst      in  1                    asynchronous active-high reset
//   req      in  NUM_CORES            per-core fetch request
//   addr     in  NUM_CORES*ADDR_W     core i address at [i*ADDR_W +: ADDR_W]
//   gnt      out NUM_CORES            combinational one-hot grant
//   rvalid   out NUM_CORES            registered one-cycle data-valid pulse
//   rdata    out NUM_CORES*DATA_W     per-core read data, held between reads
//   err      out NUM_CORES            out-of-range flag, pulses with rvalid
//   wr_en    in  1                    loader write strobe
//   wr_addr  in  ADDR_W               loader write address
//   wr_data  in  DATA_W               loader write data
//   wr_err   out 1                    registered pulse: write dropped
// -----------------------------------------------------------------------------
module iram_mp #(
    parameter int                 DATA_W     = 16,
    parameter int                 ADDR_W     = 16,
    parameter int                 DEPTH      = 1024,
    parameter int                 NUM_CORES  = 4,
    parameter logic [DATA_W-1:0]  ENDOP_WORD = 16'd51,
    parameter string              INIT_FILE  = ""
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CORES-1:0]          req,
    input  logic [NUM_CORES*ADDR_W-1:0]   addr,
    output logic [NUM_CORES-1:0]          gnt,
    output logic [NUM_CORES-1:0]          rvalid,
    output logic [NUM_CORES*DATA_W-1:0]   rdata,
    output logic [NUM_CORES-1:0]          err,
    input  logic                          wr_en,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [DATA_W-1:0]             wr_data,
    output logic                          wr_err
);

    localparam int IDX_W  = $clog2(DEPTH);
    localparam int CORE_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

`ifdef IRAM_MP_BOUNDS_EN
    localparam logic BOUNDS_EN = 1'b1;
`else
    localparam logic BOUNDS_EN = 1'b0;
`endif

    // Storage (intentionally not reset)
    logic [DATA_W-1:0] r_mem [DEPTH];

    // Registered state
    logic [CORE_W-1:0] r_last;
    logic [NUM_CORES-1:0] r_rvalid;
    logic [NUM_CORES-1:0] r_err;
    logic [DATA_W-1:0] r_rdata [NUM_CORES];
    logic r_wr_err;

    // Combinational nets
    logic [ADDR_W-1:0] w_addr_arr [NUM_CORES];
    logic [NUM_CORES-1:0] w_gnt;
    logic [CORE_W-1:0] w_gnt_idx;
    logic w_found;
    int w_cand;
    logic w_acc;
    logic [ADDR_W-1:0] w_raddr;
    logic w_roor;
    logic w_woor;
    logic w_wr_commit;
    logic [DATA_W-1:0] w_rword;

    // Unpack the flat per-core address bus and repack the per-core read data.
    genvar g;
    generate
        for (g = 0; g < NUM_CORES; g++) begin : g_port
            assign w_addr_arr[g] = addr[g*ADDR_W +: ADDR_W];
            assign rdata[g*DATA_W +: DATA_W] = r_rdata[g];
        end
    endgenerate

    // Round-robin search starting one past the last granted core.
    // A pending write suppresses every grant.
    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        w_gnt     = '0;
        w_cand    = 0;
        for (int off = 1; off <= NUM_CORES; off++) begin
            w_cand = int'(r_last) + off;
            if (w_cand >= NUM_CORES) begin
                w_cand = w_cand - NUM_CORES;
            end else begin
                w_cand = w_cand;
            end
            if (!w_found && req[CORE_W'(w_cand)]) begin
                w_found   = 1'b1;
                w_gnt_idx = CORE_W'(w_cand);
            end else begin
                w_found = w_found;
            end
        end
        if (w_found && !wr_en) begin
            w_gnt[w_gnt_idx] = 1'b1;
        end else begin
            w_gnt = '0;
        end
    end

    assign gnt   = w_gnt;
    assign w_acc = |w_gnt;

    // Address decode. The range checks collapse to 0 when bounds checking is
    // not built in, so both addresses simply wrap on their low IDX_W bits.
    assign w_raddr     = w_addr_arr[w_gnt_idx];
    assign w_roor      = BOUNDS_EN & ({1'b0, w_raddr} >= DEPTH_X);
    assign w_woor      = BOUNDS_EN & ({1'b0, wr_addr} >= DEPTH_X);
    assign w_wr_commit = wr_en & ~rst & ~w_woor;

    // Read word selection. Out-of-range reads return the end-of-program word.
    always_comb begin
        w_rword = '0;
        if (w_roor) begin
            w_rword = ENDOP_WORD;
        end else begin
            w_rword = r_mem[w_raddr[IDX_W-1:0]];
        end
    end

    // Program-load write port. Writes are suppressed while reset is held.
    always_ff @(posedge clk) begin
        if (w_wr_commit) begin
            r_mem[wr_addr[IDX_W-1:0]] <= wr_data;
        end
    end

    // Arbiter pointer, per-core read registers and write error pulse.
    // Reset sets the pointer to the last core so core 0 wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last   <= CORE_W'(NUM_CORES-1);
            r_rvalid <= '0;
            r_err    <= '0;
            r_wr_err <= 1'b0;
            for (int i = 0; i < NUM_CORES; i++) begin
                r_rdata[i] <= '0;
            end
        end else begin
            r_wr_err <= wr_en & w_woor;
            if (w_acc) begin
                r_last <= w_gnt_idx;
            end else begin
                r_last <= r_last;
            end
            for (int i = 0; i < NUM_CORES; i++) begin
                if (w_acc && (w_gnt_idx == CORE_W'(i))) begin
                    r_rvalid[i] <= 1'b1;
                    r_err[i]    <= w_roor;
                    r_rdata[i]  <= w_rword;
                end else begin
                    r_rvalid[i] <= 1'b0;
                    r_err[i]    <= 1'b0;
                end
            end
        end
    end

    assign rvalid = r_rvalid;
    assign err    = r_err;
    assign wr_err = r_wr_err;

endmodule

// File: tb/tb_iram_mp.sv
// -----------------------------------------------------------------------------
// tb_iram_mp - self-checking bench for iram_mp (4 cores, 1024 x 16).
//
// Each accepted fetch pushes its expected result, taken from a bench-side
// memory model, onto a scoreboard queue. The entry is popped and compared
// when the DUT should deliver rvalid. Inputs change 1 ns after the rising
// edge, and outputs are sampled away from the edge.
// -----------------------------------------------------------------------------
module tb_iram_mp;

    typedef struct {
        int          core;
        logic [15:0] data;
        logic        err;
    } exp_t;

`ifdef IRAM_MP_BOUNDS_EN
    localparam logic BOUNDS = 1'b1;
`else
    localparam logic BOUNDS = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [63:0] addr;
    logic [3:0]  gnt;
    logic [3:0]  rvalid;
    logic [63:0] rdata;
    logic [3:0]  err;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;
    logic        wr_err;

    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] model_mem [1024];
    logic [15:0] exp_rdata [4];
    exp_t        sb [$];

    iram_mp #(
        .DATA_W    (16),
        .ADDR_W    (16),
        .DEPTH     (1024),
        .NUM_CORES (4),
        .ENDOP_WORD(16'd51),
        .INIT_FILE ("")
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .addr   (addr),
        .gnt    (gnt),
        .rvalid (rvalid),
        .rdata  (rdata),
        .err    (err),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .wr_err (wr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_wr(input int a, input logic [15:0] d);
        if (a >= 1024) begin
            if (!BOUNDS) model_mem[a % 1024] = d;
        end else begin
            model_mem[a] = d;
        end
    endfunction

    function automatic logic [15:0] model_rd(input int a);
        if (a >= 1024 && BOUNDS) return 16'd51;
        return model_mem[a % 1024];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int a, input logic [15:0] d);
        wr_en   = 1'b1;
        wr_addr = 16'(a);
        wr_data = d;
        model_wr(a, d);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic set_addr(input int c, input int a);
        addr[c*16 +: 16] = 16'(a);
    endtask

    task automatic test_reset();
        exp_t e;
        vectors++;
        if (rvalid !== 4'b0 || err !== 4'b0 || rdata !== 64'b0 || wr_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: rvalid=%b err=%b rdata=%h wr_err=%b, want all zero",
                     rvalid, err, rdata, wr_err);
        end
        load(3, 16'hBEEF);
        set_addr(0, 3);
        req = 4'b0001;
        #1;
        vectors++;
        if (gnt !== 4'b0001) begin
            miscompares++;
            $display("FAIL pre_reset_gnt: got %b want 0001", gnt);
        end
        sb.push_back('{core: 0, data: model_rd(3), err: 1'b0});
        tick();
        req = 4'b0000;
        e = sb.pop_front();
        vectors++;
        if (rvalid !== 4'(1 << e.core) || rdata[e.core*16 +: 16] !== e.data) begin
            miscompares++;
            $display("FAIL pre_reset_read: rvalid=%b data=%h want core%0d data=%h",
                     rvalid, rdata[e.core*16 +: 16], e.core, e.data);
        end
        // Assert reset mid-cycle, while rvalid is still high.
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (rvalid !== 4'b0 || err !== 4'b0 || rdata !== 64'b0) begin
            miscompares++;
            $display("FAIL async_reset: rvalid=%b err=%b rdata=%h want zero", rvalid, err, rdata);
        end
        for (int c = 0; c < 4; c++) exp_rdata[c] = 16'h0000;
        req = 4'b1111;
        #1;
        vectors++;
        if (gnt !== 4'b0001) begin
            miscompares++;
            $display("FAIL gnt_in_reset: got %b want 0001", gnt);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        vectors++;
        if (gnt !== 4'b0001 || rvalid !== 4'b0000) begin
            miscompares++;
            $display("FAIL post_reset: gnt=%b rvalid=%b want gnt 0001 rvalid 0000", gnt, rvalid);
        end
        req = 4'b0000;
    endtask

    task automatic test_fairness();
        exp_t e;
        int   cnt [4];
        int   exp_c;
        for (int c = 0; c < 4; c++) begin
            cnt[c] = 0;
            load(20 + c, 16'hA000 + 16'(c));
            set_addr(c, 20 + c);
        end
        req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1;
            exp_c = k % 4;
            vectors++;
            if (gnt !== 4'(1 << exp_c)) begin
                miscompares++;
                $display("FAIL rr_order[%0d]: gnt=%b want core %0d", k, gnt, exp_c);
            end
            for (int c = 0; c < 4; c++) if (gnt[c]) cnt[c]++;
            sb.push_back('{core: exp_c, data: model_rd(20 + exp_c), err: 1'b0});
            tick();
            e = sb.pop_front();
            vectors++;
            if (rvalid !== 4'(1 << e.core) || err !== 4'b0000) begin
                miscompares++;
                $display("FAIL rr_rvalid[%0d]: rvalid=%b err=%b want core %0d", k, rvalid, err, e.core);
            end
            exp_rdata[e.core] = e.data;
            for (int c = 0; c < 4; c++) begin
                vectors++;
                if (rdata[c*16 +: 16] !== exp_rdata[c]) begin
                    miscompares++;
                    $display("FAIL rr_rdata[%0d] core%0d: got %h want %h", k, c,
                             rdata[c*16 +: 16], exp_rdata[c]);
                end
            end
        end
        req = 4'b0000;
        for (int c = 0; c < 4; c++) begin
            vectors++;
            if (cnt[c] !== 2) begin
                miscompares++;
                $display("FAIL rr_count core%0d: got %0d grants want 2", c, cnt[c]);
            end
        end
    endtask

    task automatic test_single_core();
        exp_t e;
        load(5, 16'h0024);
        set_addr(2, 5);
        req = 4'b0100;
        #1;
        vectors++;
        if (gnt !== 4'b0100) begin
            miscompares++;
            $display("FAIL single_gnt: got %b want 0100", gnt);
        end
        sb.push_back('{core: 2, data: model_rd(5), err: 1'b0});
        tick();
        req = 4'b0000;
        e = sb.pop_front();
        vectors++;
        if (rvalid !== 4'(1 << e.core)) begin
            miscompares++;
            $display("FAIL single_rvalid: got %b want core %0d", rvalid, e.core);
        end
        exp_rdata[e.core] = e.data;
        for (int c = 0; c < 4; c++) begin
            vectors++;
            if (rdata[c*16 +: 16] !== exp_rdata[c]) begin
                miscompares++;
                $display("FAIL single_rdata core%0d: got %h want %h", c, rdata[c*16 +: 16], exp_rdata[c]);
            end
        end
    endtask

    task automatic test_write_priority();
        exp_t e;
        set_addr(1, 10);
        req = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            wr_en   = 1'b1;
            wr_addr = 16'(10 + i);
            wr_data = 16'h5A00 + 16'(i);
            model_wr(10 + i, 16'h5A00 + 16'(i));
            #1;
            vectors++;
            if (gnt !== 4'b0000) begin
                miscompares++;
                $display("FAIL wr_prio_gnt[%0d]: got %b want 0000", i, gnt);
            end
            tick();
        end
        wr_en = 1'b0;
        vectors++;
        if (wr_err !== 1'b0 || rvalid !== 4'b0000) begin
            miscompares++;
            $display("FAIL wr_prio_idle: wr_err=%b rvalid=%b want 0 and 0000", wr_err, rvalid);
        end
        // The core reads the new word at 10 and then, back to back, the word at 11.
        for (int j = 0; j < 2; j++) begin
            set_addr(1, 10 + j);
            #1;
            vectors++;
            if (gnt !== 4'b0010) begin
                miscompares++;
                $display("FAIL b2b_gnt[%0d]: got %b want 0010", j, gnt);
            end
            sb.push_back('{core: 1, data: model_rd(10 + j), err: 1'b0});
            tick();
            e = sb.pop_front();
            vectors++;
            if (rvalid !== 4'(1 << e.core) || rdata[e.core*16 +: 16] !== e.data) begin
                miscompares++;
                $display("FAIL b2b_read[%0d]: rvalid=%b data=%h want core%0d data=%h", j,
                         rvalid, rdata[e.core*16 +: 16], e.core, e.data);
            end
            exp_rdata[e.core] = e.data;
        end
        req = 4'b0000;
    endtask

    task automatic test_out_of_range();
        exp_t e;
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 0) begin
                load(6, 16'h0606);
                set_addr(3, 1030);
                sb.push_back('{core: 3, data: model_rd(1030), err: BOUNDS});
            end else begin
                load(1030, 16'hDEAD);
                vectors++;
                if (wr_err !== BOUNDS) begin
                    miscompares++;
                    $display("FAIL wr_err_pulse: got %b want %b", wr_err, BOUNDS);
                end
                set_addr(3, 6);
                sb.push_back('{core: 3, data: model_rd(6), err: 1'b0});
            end
            req = 4'b1000;
            #1;
            vectors++;
            if (gnt !== 4'b1000) begin
                miscompares++;
                $display("FAIL oor_gnt[%0d]: got %b want 1000", pass, gnt);
            end
            tick();
            req = 4'b0000;
            e = sb.pop_front();
            vectors++;
            if (rvalid !== 4'b1000 || err !== (e.err ? 4'b1000 : 4'b0000) ||
                rdata[e.core*16 +: 16] !== e.data || wr_err !== 1'b0) begin
                miscompares++;
                $display("FAIL oor_read[%0d]: rvalid=%b err=%b data=%h wr_err=%b want err=%b data=%h",
                         pass, rvalid, err, rdata[e.core*16 +: 16], wr_err, e.err, e.data);
            end
            exp_rdata[e.core] = e.data;
        end
    endtask

    task automatic test_reset_inflight();
        exp_t e;
        set_addr(0, 20);
        req = 4'b0001;
        #2;
        rst = 1'b1;
        #1;
        for (int c = 0; c < 4; c++) exp_rdata[c] = 16'h0000;
        @(posedge clk);
        #1;
        vectors++;
        if (rvalid !== 4'b0000 || rdata !== 64'b0) begin
            miscompares++;
            $display("FAIL inflight_dropped: rvalid=%b rdata=%h want zero", rvalid, rdata);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (gnt !== 4'b0001) begin
            miscompares++;
            $display("FAIL rerequest_gnt: got %b want 0001", gnt);
        end
        sb.push_back('{core: 0, data: model_rd(20), err: 1'b0});
        tick();
        req = 4'b0000;
        e = sb.pop_front();
        vectors++;
        if (rvalid !== 4'(1 << e.core) || rdata[e.core*16 +: 16] !== e.data) begin
            miscompares++;
            $display("FAIL rerequest_read: rvalid=%b data=%h want core%0d data=%h",
                     rvalid, rdata[e.core*16 +: 16], e.core, e.data);
        end
    endtask

    initial begin
        rst     = 1'b1;
        req     = 4'b0000;
        addr    = 64'b0;
        wr_en   = 1'b0;
        wr_addr = 16'h0000;
        wr_data = 16'h0000;
        for (int c = 0; c < 4; c++) exp_rdata[c] = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        test_reset();
        test_fairness();
        test_single_core();
        test_write_priority();
        test_out_of_range();
        test_reset_inflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
